// File: rtl/turing_pkg.sv
// turing_pkg: shared state encoding and default word width for the serial link
package turing_pkg;
  typedef enum logic {IDLE, SHIFT} tx_state_t;
  localparam int WORD_W = 8;
endpackage

// File: rtl/shift_register_piso_tx_counter.sv
// shift_register_piso_tx_counter: loadable up/down bit counter with synchronous clear
module shift_register_piso_tx_counter #(
  parameter int CW = 3
) (
  input  logic          clock,
  input  logic          reset_L,
  input  logic          clear,
  input  logic          load,
  input  logic          en,
  input  logic          up,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] count
);
  logic [CW-1:0] count_q, count_d;
  // clear beats load, load beats counting
  always_comb count_d = clear ? '0 : load ? load_val : en ? (up ? count_q + 1'b1 : count_q - 1'b1) : count_q;
  // count register, asynchronously reset
  always_ff @(posedge clock or negedge reset_L)
    if (!reset_L) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/shift_register_piso_tx.sv
// shift_register_piso_tx: handshaked parallel-in/serial-out transmitter, MSB- or LSB-first
module shift_register_piso_tx
  import turing_pkg::*;
#(
  parameter int W  = WORD_W,
  parameter int CW = $clog2(W)
) (
  input  logic         clock,
  input  logic         reset_L,
  input  logic         clear,
  input  logic [W-1:0] data_in,
  input  logic         left,
  input  logic         valid_in,
  output logic         ready_out,
  input  logic         shift_en,
  output logic         serial_out,
  output logic         serial_valid,
  output logic         frame_last,
  output logic         busy
);
  tx_state_t     state_q, state_d;
  logic [W-1:0]  sreg_q, sreg_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] count;
  logic          accept, advance, in_shift;
  assign in_shift  = state_q == SHIFT;
  assign advance   = in_shift && shift_en;
  assign ready_out = !clear && (state_q == IDLE || (advance && count == '0));
  assign accept    = valid_in && ready_out;
  shift_register_piso_tx_counter #(.CW(CW)) u_count (
    .clock    (clock),
    .reset_L  (reset_L),
    .clear    (clear),
    .load     (accept),
    .en       (advance && count != '0),
    .up       (1'b0),
    .load_val (CW'(W - 1)),
    .count    (count)
  );
  // next state: clear aborts, accept (re)loads, advance shifts toward the output end or finishes
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    dir_d   = dir_q;
    if (clear) begin
      state_d = IDLE;
      sreg_d  = '0;
    end else if (accept) begin
      state_d = SHIFT;
      sreg_d  = data_in;
      dir_d   = left;
    end else if (advance) begin
      if (count != '0) sreg_d = dir_q ? sreg_q << 1 : sreg_q >> 1;
      else begin
        state_d = IDLE;
        sreg_d  = '0;
      end
    end
  end
  // state, shift register and direction flops, asynchronously reset
  always_ff @(posedge clock or negedge reset_L)
    if (!reset_L) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      dir_q   <= dir_d;
    end
  assign serial_out   = in_shift && (dir_q ? sreg_q[W-1] : sreg_q[0]);
  assign serial_valid = in_shift;
  assign frame_last   = in_shift && count == '0;
  assign busy         = in_shift;
endmodule
